pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
//  - Detects load-use hazards between ID and EX.
//  - Squashes wrong-path instructions when a branch or jump resolves taken in MEM.
//  - Holds the front end while a multi-cycle multiply/divide unit (MDU) works, with a watchdog timeout.
//  - Drives the PC write enable and the IF/ID, ID/EX and EX/MEM write-enable and flush controls.
// PARAMETERS
//  MDU_TIMEOUT  64  maximum MDU_WAIT cycles before the operation is aborted; must be >= 2
//  CNT_W        16  width of the performance counters (only used when the macro is defined)
// PORTS
//  Clock               in   1   rising-edge clock
//  Reset               in   1   synchronous, active-high reset
//  rs_ID               in   5   Instruction_ID[25:21]
//  rt_ID               in   5   Instruction_ID[20:16]
//  UsesRt_ID           in   1   ID instruction reads rt as a source
//  R_Enable_EX         in   1   EX instruction is a load
//  RegWrite_EX         in   1   EX instruction writes the register file
//  RegDestSelected_EX  in   5   destination register of the EX instruction
//  BranchTaken_MEM     in   1   PCSel from MEM; the redirect is taken this cycle
//  MduStart_ID         in   1   ID instruction is a multi-cycle MDU op
//  MduDone             in   1   MDU result valid; single-cycle pulse
//  PCWrite             out  1   PC register update enable
//  IF_ID_Write         out  1   IF/ID register update enable
//  IF_ID_Flush         out  1   load a NOP into IF/ID
//  ID_EX_Flush         out  1   load a bubble into ID/EX (all control bits 0)
//  EX_MEM_Flush        out  1   load a bubble into EX/MEM
//  MduGo               out  1   one-cycle start pulse to the MDU
//  MduAbort            out  1   one-cycle cancel pulse to the MDU
//  MduError            out  1   sticky flag: watchdog expired
//  State               out  2   00 RUN, 01 MDU_WAIT
// BEHAVIOUR
//  - Registered state: one 2-bit FSM register, a watchdog counter of $clog2(MDU_TIMEOUT+1) bits, and MduError.
//  - All other outputs are combinational from the state and the current inputs (zero latency).
//  - Reset (sampled on the clock edge):
//    - State=RUN, counter=0, MduError=0.
//    - While Reset=1: PCWrite=0, IF_ID_Write=0, all three flushes=1, MduGo=0, MduAbort=0.
//  - Default outputs in RUN: PCWrite=1, IF_ID_Write=1, all flushes=0, MduGo=0, MduAbort=0.
//  - Load-use hazard LU = R_Enable_EX & RegWrite_EX & (RegDestSelected_EX!=0) &
//    ((RegDestSelected_EX==rs_ID) | (UsesRt_ID & RegDestSelected_EX==rt_ID)).
//  - Priority each cycle, highest first: Reset > BranchTaken_MEM > MDU_WAIT handling > LU > MduStart_ID.
//  - Branch (any state):
//    - IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1, PCWrite=1 (loads the target), IF_ID_Write=1.
//    - If in MDU_WAIT: MduAbort=1 and next state is RUN. The counter clears.
//  - RUN with LU (and no branch):
//    - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Exactly one bubble per hazard.
//    - MduStart_ID is ignored this cycle.
//  - RUN with MduStart_ID, no LU, no branch:
//    - MduGo=1, next state is MDU_WAIT, counter=0.
//    - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. The MDU op stays in ID.
//  - MDU_WAIT, no branch:
//    - MduDone=1: next state is RUN. Outputs are the RUN defaults this same cycle, so the op advances to EX with the result.
//    - MduDone=0 and counter==MDU_TIMEOUT-1: MduAbort=1, MduError set (sticky until Reset), next state is RUN.
//      Outputs are the RUN defaults and the op advances.
//    - Otherwise: counter+1, PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
//  - MduDone while in RUN is ignored.
//  - LU is not evaluated in MDU_WAIT; EX holds only bubbles there.
//  - Reset mid-MDU_WAIT: return to RUN with no MduAbort pulse. The MDU is reset by the same Reset.
//  - Encodings 10 and 11 are unreachable; if ever entered, the next state is RUN.
// CONFIGURATION
//  HAZARD_PERF_COUNTERS_EN defined:
//    - Adds outputs LuStallCount[CNT_W-1:0], MduStallCount[CNT_W-1:0], FlushCount[CNT_W-1:0].
//    - LuStallCount increments on each LU bubble.
//    - MduStallCount increments on each MDU_WAIT cycle with PCWrite=0, plus the MduGo cycle.
//    - FlushCount increments on each branch flush.
//    - Counters saturate at all-ones and clear on Reset.
//  Not defined: these ports and registers do not exist; behaviour is otherwise identical.
// TESTING
//  1. LU on rs:
//     - Stimulus: R_Enable_EX=1, RegWrite_EX=1, RegDestSelected_EX=8, rs_ID=8.
//     - Required: one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. After EX advances, PCWrite=1.
//  2. No hazard on $zero or an unused rt:
//     - Stimulus: RegDestSelected_EX=0 with rs_ID=0, or dest=9, rt_ID=9, UsesRt_ID=0.
//     - Required: no stall.
//  3. MDU op with MduDone 5 cycles after MduGo:
//     - Required: MduGo for 1 cycle, State=01 for 5 cycles with 5 bubbles.
//     - On the MduDone cycle: State returns to 00 and PCWrite=1.
//  4. MDU timeout, MDU_TIMEOUT=8, MduDone never asserted:
//     - Required: MduAbort and MduError rise in wait cycle 8, State=00, MduError stays 1 until Reset.
//  5. BranchTaken_MEM=1 in wait cycle 3:
//     - Required: all three flushes=1, PCWrite=1, MduAbort=1, State=00 next cycle.
//     - The same cycle with LU=1 is also covered: the branch wins and there is no stall.
//  6. Reset asserted mid-MDU_WAIT:
//     - Required: State=00, MduError=0, and with the macro defined all counters read 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Control bus between the pipeline datapath and the hazard controller.
// Counter signals exist only when HAZARD_PERF_COUNTERS_EN is defined.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0] rs_ID;
  logic [4:0] rt_ID;
  logic       UsesRt_ID;
  logic       R_Enable_EX;
  logic       RegWrite_EX;
  logic [4:0] RegDestSelected_EX;
  logic       BranchTaken_MEM;
  logic       MduStart_ID;
  logic       MduDone;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       EX_MEM_Flush;
  logic       MduGo;
  logic       MduAbort;
  logic       MduError;
  logic [1:0] State;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] LuStallCount;
  logic [CNT_W-1:0] MduStallCount;
  logic [CNT_W-1:0] FlushCount;
`endif

  modport slave (
    input  rs_ID, rt_ID, UsesRt_ID, R_Enable_EX, RegWrite_EX, RegDestSelected_EX,
    input  BranchTaken_MEM, MduStart_ID, MduDone,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
    output MduGo, MduAbort, MduError, State
`ifdef HAZARD_PERF_COUNTERS_EN
    , output LuStallCount, MduStallCount, FlushCount
`endif
  );

  modport master (
    output rs_ID, rt_ID, UsesRt_ID, R_Enable_EX, RegWrite_EX, RegDestSelected_EX,
    output BranchTaken_MEM, MduStart_ID, MduDone,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
    input  MduGo, MduAbort, MduError, State
`ifdef HAZARD_PERF_COUNTERS_EN
    , input LuStallCount, MduStallCount, FlushCount
`endif
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, MDU wait with watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_controller #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic                        Clock,
  input logic                        Reset,
  pipeline_hazard_controller_if.slave bus
);
  localparam int CW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MDU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_WAIT = 2'b01
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          err_r, err_nxt_s;
  logic          lu_s;
  logic          pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s, exmem_flush_s;
  logic          go_s, abort_s;

  // Load-use: EX load targets a register the ID instruction reads.
  assign lu_s = bus.R_Enable_EX && bus.RegWrite_EX && (bus.RegDestSelected_EX != 5'd0) &&
                ((bus.RegDestSelected_EX == bus.rs_ID) ||
                 (bus.UsesRt_ID && (bus.RegDestSelected_EX == bus.rt_ID)));

  // Next-state and zero-latency pipeline controls.
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    go_s          = 1'b0;
    abort_s       = 1'b0;
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    err_nxt_s     = err_r;
    if (Reset) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_flush_s = 1'b1;
      state_nxt_s   = RUN;
      cnt_nxt_s     = '0;
      err_nxt_s     = 1'b0;
    end else if (bus.BranchTaken_MEM) begin
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_flush_s = 1'b1;
      abort_s       = (state_r == MDU_WAIT);
      state_nxt_s   = RUN;
      cnt_nxt_s     = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (lu_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
          end else if (bus.MduStart_ID) begin
            go_s         = 1'b1;
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
            state_nxt_s  = MDU_WAIT;
            cnt_nxt_s    = '0;
          end else begin
            state_nxt_s  = RUN;
          end
        end
        MDU_WAIT: begin
          if (bus.MduDone) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
          end else if (cnt_r == CNT_LAST) begin
            abort_s     = 1'b1;
            err_nxt_s   = 1'b1;
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s    = cnt_r + CW'(1);
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // FSM, watchdog and sticky error registers.
  always_ff @(posedge Clock) begin
    state_r <= state_nxt_s;
    cnt_r   <= cnt_nxt_s;
    err_r   <= err_nxt_s;
  end

  assign bus.PCWrite      = pc_write_s;
  assign bus.IF_ID_Write  = ifid_write_s;
  assign bus.IF_ID_Flush  = ifid_flush_s;
  assign bus.ID_EX_Flush  = idex_flush_s;
  assign bus.EX_MEM_Flush = exmem_flush_s;
  assign bus.MduGo        = go_s;
  assign bus.MduAbort     = abort_s;
  assign bus.MduError     = err_r;
  assign bus.State        = state_r;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] lu_cnt_r, mdu_cnt_r, fl_cnt_r;
  logic             lu_ev_s, mdu_ev_s, fl_ev_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    else return v;
  endfunction

  // A stall that is neither reset nor load-use is always an MDU go or wait bubble.
  assign lu_ev_s  = !Reset && !bus.BranchTaken_MEM && (state_r == RUN) && lu_s;
  assign mdu_ev_s = !Reset && !pc_write_s && !lu_ev_s;
  assign fl_ev_s  = !Reset && bus.BranchTaken_MEM;

  // Saturating event counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lu_cnt_r  <= '0;
      mdu_cnt_r <= '0;
      fl_cnt_r  <= '0;
    end else begin
      lu_cnt_r  <= sat_inc(lu_cnt_r, lu_ev_s);
      mdu_cnt_r <= sat_inc(mdu_cnt_r, mdu_ev_s);
      fl_cnt_r  <= sat_inc(fl_cnt_r, fl_ev_s);
    end
  end

  assign bus.LuStallCount  = lu_cnt_r;
  assign bus.MduStallCount = mdu_cnt_r;
  assign bus.FlushCount    = fl_cnt_r;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MDU_TIMEOUT = 8).
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Control vector order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MduGo, MduAbort
  localparam logic [6:0] C_RST   = 7'b0011100;
  localparam logic [6:0] C_RUN   = 7'b1100000;
  localparam logic [6:0] C_STALL = 7'b0001000;
  localparam logic [6:0] C_GO    = 7'b0001010;
  localparam logic [6:0] C_BR    = 7'b1111100;
  localparam logic [6:0] C_BRAB  = 7'b1111101;
  localparam logic [6:0] C_TOUT  = 7'b1100001;

  pipeline_hazard_controller_if bus ();

  pipeline_hazard_controller #(.MDU_TIMEOUT(8)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
            bus.EX_MEM_Flush, bus.MduGo, bus.MduAbort};
  endfunction

  task automatic idle();
    bus.rs_ID = 5'd0; bus.rt_ID = 5'd0; bus.UsesRt_ID = 1'b0;
    bus.R_Enable_EX = 1'b0; bus.RegWrite_EX = 1'b0; bus.RegDestSelected_EX = 5'd0;
    bus.BranchTaken_MEM = 1'b0; bus.MduStart_ID = 1'b0; bus.MduDone = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt);
    bus.R_Enable_EX = 1'b1; bus.RegWrite_EX = 1'b1;
    bus.RegDestSelected_EX = dest; bus.rs_ID = rs; bus.rt_ID = rt; bus.UsesRt_ID = uses_rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check_eq("reset_ctl", 32'(ctl()), 32'(C_RST));
    tick();
    tick();
    check_eq("reset_state", 32'(bus.State), 32'd0);
    check_eq("reset_err", 32'(bus.MduError), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("run_default", 32'(ctl()), 32'(C_RUN));
    tick();

    // 1. load-use on rs, then on rt
    set_lu(5'd8, 5'd8, 5'd3, 1'b0);
    #1; check_eq("lu_rs_stall", 32'(ctl()), 32'(C_STALL));
    tick();
    idle();
    #1; check_eq("lu_rs_release", 32'(ctl()), 32'(C_RUN));
    tick();
    set_lu(5'd8, 5'd3, 5'd8, 1'b1);
    bus.MduStart_ID = 1'b1;
    #1; check_eq("lu_rt_stall_start_ignored", 32'(ctl()), 32'(C_STALL));
    tick();
    check_eq("lu_no_mdu_entry", 32'(bus.State), 32'd0);
    idle();

    // 2. no hazard cases
    set_lu(5'd0, 5'd0, 5'd0, 1'b1);
    #1; check_eq("no_lu_zero", 32'(ctl()), 32'(C_RUN));
    tick();
    set_lu(5'd9, 5'd1, 5'd9, 1'b0);
    #1; check_eq("no_lu_unused_rt", 32'(ctl()), 32'(C_RUN));
    tick();
    set_lu(5'd9, 5'd9, 5'd2, 1'b0);
    bus.RegWrite_EX = 1'b0;
    #1; check_eq("no_lu_no_regwrite", 32'(ctl()), 32'(C_RUN));
    tick();
    idle();
    bus.MduDone = 1'b1;
    #1; check_eq("done_in_run", 32'(ctl()), 32'(C_RUN));
    tick();
    check_eq("done_in_run_state", 32'(bus.State), 32'd0);
    idle();

    // 3. MDU op, MduDone on the 5th wait cycle
    bus.MduStart_ID = 1'b1;
    #1; check_eq("mdu_go", 32'(ctl()), 32'(C_GO));
    tick();
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("mdu_wait%0d_state", i), 32'(bus.State), 32'd1);
      check_eq($sformatf("mdu_wait%0d_ctl", i), 32'(ctl()), 32'(C_STALL));
      tick();
    end
    bus.MduDone = 1'b1;
    #1;
    check_eq("mdu_done_state", 32'(bus.State), 32'd1);
    check_eq("mdu_done_ctl", 32'(ctl()), 32'(C_RUN));
    tick();
    idle();
    check_eq("mdu_back_run", 32'(bus.State), 32'd0);
    check_eq("mdu_no_err", 32'(bus.MduError), 32'd0);

    // 4. watchdog timeout at wait cycle 8
    bus.MduStart_ID = 1'b1;
    #1; check_eq("tout_go", 32'(ctl()), 32'(C_GO));
    tick();
    for (int i = 1; i <= 7; i++) begin
      check_eq($sformatf("tout_wait%0d_ctl", i), 32'(ctl()), 32'(C_STALL));
      tick();
    end
    check_eq("tout_wait8_state", 32'(bus.State), 32'd1);
    check_eq("tout_wait8_ctl", 32'(ctl()), 32'(C_TOUT));
    tick();
    idle();
    check_eq("tout_state", 32'(bus.State), 32'd0);
    check_eq("tout_err", 32'(bus.MduError), 32'd1);
    tick();
    tick();
    check_eq("tout_err_sticky", 32'(bus.MduError), 32'd1);

    // 5. branch in wait cycle 3 together with a load-use pattern
    bus.MduStart_ID = 1'b1;
    tick();
    tick();
    set_lu(5'd4, 5'd4, 5'd0, 1'b0);
    #1; check_eq("br_wait2_lu_ignored", 32'(ctl()), 32'(C_STALL));
    tick();
    bus.BranchTaken_MEM = 1'b1;
    #1; check_eq("br_wait3_ctl", 32'(ctl()), 32'(C_BRAB));
    tick();
    check_eq("br_wait3_state", 32'(bus.State), 32'd0);
    #1; check_eq("br_run_lu_ctl", 32'(ctl()), 32'(C_BR));
    tick();
    bus.BranchTaken_MEM = 1'b0;
    bus.MduStart_ID = 1'b0;
    #1; check_eq("lu_after_branch", 32'(ctl()), 32'(C_STALL));
    tick();
    idle();
    check_eq("err_still_sticky", 32'(bus.MduError), 32'd1);

    // 6. reset in the middle of MDU_WAIT
    bus.MduStart_ID = 1'b1;
    tick();
    tick();
    check_eq("rst_mid_state_pre", 32'(bus.State), 32'd1);
    rst = 1'b1;
    #1; check_eq("rst_mid_ctl_no_abort", 32'(ctl()), 32'(C_RST));
    tick();
    check_eq("rst_mid_state", 32'(bus.State), 32'd0);
    check_eq("rst_mid_err", 32'(bus.MduError), 32'd0);
`ifdef HAZARD_PERF_COUNTERS_EN
    check_eq("rst_lu_cnt", 32'(bus.LuStallCount), 32'd0);
    check_eq("rst_mdu_cnt", 32'(bus.MduStallCount), 32'd0);
    check_eq("rst_fl_cnt", 32'(bus.FlushCount), 32'd0);
`endif
    rst = 1'b0;
    idle();
    #1; check_eq("post_rst_run", 32'(ctl()), 32'(C_RUN));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
